branch_predict_gshare: RTL and testbench

BRANCH_PREDICT_GSHARE -- requirements
Module: branch_predict_gshare

---
 rtl/branch_predict_gshare_pkg.sv | 29 ++
 rtl/branch_predict_gshare_if.sv | 32 +++
 rtl/branch_predict_gshare_table.sv | 45 ++++
 rtl/branch_predict_gshare.sv | 133 +++++++++++++
 tb/tb_branch_predict_gshare.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/branch_predict_gshare_pkg.sv
// Shared types and constants for the gshare branch predictor.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
package branch_predict_gshare_pkg;

   // Init sweeps the table once after reset, then the predictor runs until the next reset.
   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Operation applied by the table write port to the addressed counter.
   typedef enum logic [1:0] {
      WR_SET = 2'b00,
      WR_INC = 2'b01,
      WR_DEC = 2'b10
   } wr_op_e;

   // Upper saturation limit of a ctr_bits-wide counter; the lower limit is 0.
   function automatic int ctr_max(input int ctr_bits);
      return (1 << ctr_bits) - 1;
   endfunction

   // Weakly-not-taken: the largest value whose MSB is still 0.
   function automatic int ctr_wnt(input int ctr_bits);
      return (1 << (ctr_bits - 1)) - 1;
   endfunction

endpackage

// File: rtl/branch_predict_gshare_if.sv
// Lookup/update/status bundle between the predictor and its caller.
// Latency: n/a (wires only).
// Backpressure: none; the caller must hold off until ready_out is high.
interface bp_if #(
   parameter int INDEX_BITS = 6,
   parameter int HIST_BITS  = 4
);
   localparam int GW = (HIST_BITS > 0) ? HIST_BITS : 1;

   logic [31:0]           pc_in;
   logic                  lookup_valid_in;
   logic                  pred_valid_out;
   logic                  branch_taken_out;
   logic [INDEX_BITS-1:0] pred_index_out;
   logic                  update_valid_in;
   logic [INDEX_BITS-1:0] update_index_in;
   logic                  correct_branch;
   logic                  ready_out;
   logic [GW-1:0]         ghr_out;

   // Caller side.
   modport master (
      output pc_in, lookup_valid_in, update_valid_in, update_index_in, correct_branch,
      input  pred_valid_out, branch_taken_out, pred_index_out, ready_out, ghr_out
   );

   // Predictor side.
   modport slave (
      input  pc_in, lookup_valid_in, update_valid_in, update_index_in, correct_branch,
      output pred_valid_out, branch_taken_out, pred_index_out, ready_out, ghr_out
   );
endinterface

// File: rtl/branch_predict_gshare_table.sv
// Pattern table of saturating counters: one synchronous read port, one write port.
// Latency: read data valid one cycle after rd_en; write takes effect at the edge.
// Backpressure: none; both ports accept every cycle, read-first on address collision.
module bp_table
   import branch_predict_gshare_pkg::*;
#(
   parameter int DEPTH_BITS = 6,
   parameter int WIDTH      = 2
) (
   input  logic                  clk_in,
   input  logic                  rd_en,
   input  logic [DEPTH_BITS-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_dat,
   input  logic                  wr_en,
   input  wr_op_e                wr_op,
   input  logic [DEPTH_BITS-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_dat
);
   localparam logic [WIDTH-1:0] CTR_MAX = WIDTH'(ctr_max(WIDTH));

   logic [WIDTH-1:0] mem [2**DEPTH_BITS];
   logic [WIDTH-1:0] wr_cur;
   logic [WIDTH-1:0] wr_nxt;
   logic [WIDTH-1:0] rd_dat_q;

   // The write port does the saturating read-modify-write itself, so the caller only supplies an index.
   always_comb begin
      wr_cur = mem[wr_addr];
      wr_nxt = wr_cur;
      case (wr_op)
         WR_SET:  wr_nxt = wr_dat;
         WR_INC:  if (wr_cur != CTR_MAX) wr_nxt = wr_cur + WIDTH'(1);
         WR_DEC:  if (wr_cur != '0)      wr_nxt = wr_cur - WIDTH'(1);
         default: wr_nxt = wr_cur;
      endcase
   end

   // Storage is not reset; both ports sample the old contents, giving read-first behaviour.
   always_ff @(posedge clk_in) begin
      if (wr_en) mem[wr_addr] <= wr_nxt;
      if (rd_en) rd_dat_q <= mem[rd_addr];
   end

   assign rd_dat = rd_dat_q;
endmodule

// File: rtl/branch_predict_gshare.sv
// Gshare/bimodal direction predictor with non-speculative global history.
// Latency: prediction one cycle after an accepted lookup; ready 2^INDEX_BITS cycles after reset.
// Backpressure: none in RUN; lookups and updates are dropped while ready_out is low.
module branch_predict_gshare
   import branch_predict_gshare_pkg::*;
#(
   parameter int INDEX_BITS = 6,
   parameter int HIST_BITS  = 4,
   parameter int CTR_BITS   = 2,
   parameter int GSHARE     = 1
) (
   input logic  clk_in,
   input logic  rst_in,
   bp_if.slave  bus
);
   localparam int                    GW       = (HIST_BITS > 0) ? HIST_BITS : 1;
   localparam logic [INDEX_BITS-1:0] LAST_IDX = '1;
   localparam logic [CTR_BITS-1:0]   CTR_WNT  = CTR_BITS'(ctr_wnt(CTR_BITS));

   state_e                state_q, state_d;
   logic [INDEX_BITS-1:0] init_idx_q, init_idx_d;
   logic                  pred_vld_q, pred_vld_d;
   logic [INDEX_BITS-1:0] pred_idx_q, pred_idx_d;
   logic [GW-1:0]         ghr_q;
   logic [INDEX_BITS-1:0] hist_ext;
   logic [INDEX_BITS-1:0] lkp_idx;
   logic                  lkp_acc;
   logic                  upd_acc;
   logic                  tbl_wr_en;
   wr_op_e                tbl_wr_op;
   logic [INDEX_BITS-1:0] tbl_wr_addr;
   logic [CTR_BITS-1:0]   tbl_wr_dat;
   logic [CTR_BITS-1:0]   tbl_rd_dat;
   logic                  unused_pc;

   // Only the word-index bits of the PC hash into the table.
   assign unused_pc = ^{bus.pc_in[31:INDEX_BITS+2], bus.pc_in[1:0]};

   // Lookup index: PC word bits, folded with the pre-update history in gshare mode.
   always_comb begin
      hist_ext = '0;
      if (GSHARE != 0) hist_ext = INDEX_BITS'(ghr_q);
      lkp_idx = bus.pc_in[INDEX_BITS+1:2] ^ hist_ext;
   end

   // Next-state logic: the sweep owns the write port in INIT, resolved updates own it in RUN.
   always_comb begin
      state_d     = state_q;
      init_idx_d  = init_idx_q;
      lkp_acc     = 1'b0;
      upd_acc     = 1'b0;
      tbl_wr_en   = 1'b0;
      tbl_wr_op   = WR_SET;
      tbl_wr_addr = init_idx_q;
      tbl_wr_dat  = CTR_WNT;
      case (state_q)
         ST_INIT: begin
            tbl_wr_en = 1'b1;
            if (init_idx_q == LAST_IDX) state_d = ST_RUN;
            else                        init_idx_d = init_idx_q + INDEX_BITS'(1);
         end
         ST_RUN: begin
            lkp_acc     = bus.lookup_valid_in;
            upd_acc     = bus.update_valid_in;
            tbl_wr_en   = upd_acc;
            tbl_wr_op   = bus.correct_branch ? WR_INC : WR_DEC;
            tbl_wr_addr = bus.update_index_in;
         end
         default: state_d = ST_INIT;
      endcase
   end

   // Prediction pipeline: valid for one cycle, index held between lookups.
   always_comb begin
      pred_vld_d = lkp_acc;
      pred_idx_d = lkp_acc ? lkp_idx : pred_idx_q;
   end

   // Control and prediction registers.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= ST_INIT;
         init_idx_q <= '0;
         pred_vld_q <= 1'b0;
         pred_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         init_idx_q <= init_idx_d;
         pred_vld_q <= pred_vld_d;
         pred_idx_q <= pred_idx_d;
      end
   end

   generate
      if (HIST_BITS > 0) begin : g_ghr
         logic [GW-1:0] ghr_d;

         // History advances only on resolved outcomes, never on lookups.
         always_comb begin
            ghr_d = ghr_q;
            if (upd_acc) ghr_d = (ghr_q << 1) | GW'(bus.correct_branch);
         end

         // Global history register.
         always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) ghr_q <= '0;
            else        ghr_q <= ghr_d;
         end
      end else begin : g_no_ghr
         assign ghr_q = '0;
      end
   endgenerate

   bp_table #(
      .DEPTH_BITS (INDEX_BITS),
      .WIDTH      (CTR_BITS)
   ) u_table (
      .clk_in  (clk_in),
      .rd_en   (lkp_acc),
      .rd_addr (lkp_idx),
      .rd_dat  (tbl_rd_dat),
      .wr_en   (tbl_wr_en),
      .wr_op   (tbl_wr_op),
      .wr_addr (tbl_wr_addr),
      .wr_dat  (tbl_wr_dat)
   );

   assign bus.pred_valid_out   = pred_vld_q;
   assign bus.branch_taken_out = pred_vld_q & tbl_rd_dat[CTR_BITS-1];
   assign bus.pred_index_out   = pred_idx_q;
   assign bus.ready_out        = (state_q == ST_RUN);
   assign bus.ghr_out          = ghr_q;
endmodule

// File: tb/tb_branch_predict_gshare.sv
// Directed bench: three predictor configurations driven by one shared stimulus stream.
// Latency: n/a.
// Backpressure: n/a.
module tb_branch_predict_gshare;
   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic [31:0] pc  = '0;
   logic        lkv = 1'b0;
   logic        upv = 1'b0;
   logic [5:0]  upi = '0;
   logic        cb  = 1'b0;
   int          total = 0;
   int          bad   = 0;

   always #5 clk_in = ~clk_in;

   // a: gshare default, b: bimodal, c: bimodal with 3-bit counters
   bp_if #(.INDEX_BITS(6), .HIST_BITS(4)) ifa ();
   bp_if #(.INDEX_BITS(6), .HIST_BITS(4)) ifb ();
   bp_if #(.INDEX_BITS(6), .HIST_BITS(4)) ifc ();

   assign ifa.pc_in = pc;  assign ifa.lookup_valid_in = lkv;  assign ifa.update_valid_in = upv;
   assign ifa.update_index_in = upi;  assign ifa.correct_branch = cb;
   assign ifb.pc_in = pc;  assign ifb.lookup_valid_in = lkv;  assign ifb.update_valid_in = upv;
   assign ifb.update_index_in = upi;  assign ifb.correct_branch = cb;
   assign ifc.pc_in = pc;  assign ifc.lookup_valid_in = lkv;  assign ifc.update_valid_in = upv;
   assign ifc.update_index_in = upi;  assign ifc.correct_branch = cb;

   branch_predict_gshare #(.INDEX_BITS(6), .HIST_BITS(4), .CTR_BITS(2), .GSHARE(1))
      dut_a (.clk_in(clk_in), .rst_in(rst_in), .bus(ifa));
   branch_predict_gshare #(.INDEX_BITS(6), .HIST_BITS(4), .CTR_BITS(2), .GSHARE(0))
      dut_b (.clk_in(clk_in), .rst_in(rst_in), .bus(ifb));
   branch_predict_gshare #(.INDEX_BITS(6), .HIST_BITS(4), .CTR_BITS(3), .GSHARE(0))
      dut_c (.clk_in(clk_in), .rst_in(rst_in), .bus(ifc));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // Count cycles until ready, starting from n0 cycles already spent since release.
   task automatic wait_ready(input string tag, input int n0);
      int n;
      n = n0;
      while (!(ifa.ready_out && ifc.ready_out) && n < 200) begin
         tick();
         n++;
      end
      check_eq(tag, n, 64);
   endtask

   task automatic reset_and_wait(input string tag);
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      wait_ready(tag, 0);
   endtask

   // Returns in the cycle where the prediction is visible.
   task automatic lookup(input logic [31:0] p);
      pc  = p;
      lkv = 1'b1;
      tick();
      lkv = 1'b0;
   endtask

   task automatic update(input logic [5:0] idx, input logic taken);
      upv = 1'b1;
      upi = idx;
      cb  = taken;
      tick();
      upv = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt;

      // async reset, no clock edge yet
      #1 rst_in = 1'b1;
      #1;
      check_eq("rst_ready", ifa.ready_out, 0);
      check_eq("rst_pvld", ifa.pred_valid_out, 0);
      check_eq("rst_taken", ifa.branch_taken_out, 0);
      check_eq("rst_pidx", ifa.pred_index_out, 0);
      check_eq("rst_ghr", ifa.ghr_out, 0);

      // traffic during INIT is ignored
      tick();
      rst_in = 1'b0;
      pc = 32'h10; lkv = 1'b1; upv = 1'b1; upi = 6'd3; cb = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      lkv = 1'b0; upv = 1'b0;
      check_eq("init_pvld", ifa.pred_valid_out, 0);
      check_eq("init_ghr", ifa.ghr_out, 0);
      wait_ready("ready_lat0", 10);

      // plain lookup: pc 0x123 -> index 8, weakly not taken
      lookup(32'h123);
      check_eq("lk_vld", ifa.pred_valid_out, 1);
      check_eq("lk_taken", ifa.branch_taken_out, 0);
      check_eq("lk_idx", ifa.pred_index_out, 8);
      tick();
      check_eq("lk_vld_drop", ifa.pred_valid_out, 0);
      check_eq("lk_taken_drop", ifa.branch_taken_out, 0);
      check_eq("lk_idx_hold", ifa.pred_index_out, 8);

      // bimodal counter walk at index 1
      for (int i = 0; i < 3; i++) update(6'd1, 1'b1);
      lookup(32'h4);  check_eq("bim_3T", ifb.branch_taken_out, 1);
      update(6'd1, 1'b1); update(6'd1, 1'b1);
      update(6'd1, 1'b0);
      lookup(32'h4);  check_eq("bim_N1", ifb.branch_taken_out, 1);
      update(6'd1, 1'b0);
      lookup(32'h4);  check_eq("bim_N2", ifb.branch_taken_out, 0);
      update(6'd1, 1'b0); update(6'd1, 1'b0);
      update(6'd1, 1'b1);
      lookup(32'h4);  check_eq("bim_floor_T1", ifb.branch_taken_out, 0);
      update(6'd1, 1'b1);
      lookup(32'h4);  check_eq("bim_floor_T2", ifb.branch_taken_out, 1);

      // history T,T,N,T then hashed lookup
      reset_and_wait("ready_lat1");
      update(6'd10, 1'b1); update(6'd10, 1'b1); update(6'd10, 1'b0); update(6'd10, 1'b1);
      check_eq("ghr_TTNT", ifa.ghr_out, 4'b1101);
      lookup(32'h40);
      check_eq("gs_idx", ifa.pred_index_out, 6'b011101);
      check_eq("gs_taken", ifa.branch_taken_out, 0);

      // same-cycle lookup and update at index 5
      reset_and_wait("ready_lat2");
      pc = 32'h14; lkv = 1'b1; upv = 1'b1; upi = 6'd5; cb = 1'b1;
      tick();
      lkv = 1'b0; upv = 1'b0;
      check_eq("rf_taken", ifb.branch_taken_out, 0);
      check_eq("rf_gs_idx", ifa.pred_index_out, 5);
      check_eq("rf_ghr", ifa.ghr_out, 1);
      lookup(32'h14);
      check_eq("rf_next_taken", ifb.branch_taken_out, 1);

      // reset at cycle 30 of INIT
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      for (int i = 0; i < 30; i++) tick();
      check_eq("mid_init_ready", ifa.ready_out, 0);
      rst_in = 1'b1;
      #1;
      check_eq("mid_init_rst_ready", ifa.ready_out, 0);
      tick();
      rst_in = 1'b0;
      wait_ready("ready_lat3", 0);

      // train, then reset while a prediction is pending
      for (int i = 0; i < 8; i++) begin
         update(6'(i), 1'b1);
         update(6'(i), 1'b1);
      end
      lookup(32'h4);
      check_eq("trained_taken", ifb.branch_taken_out, 1);
      check_eq("trained_vld", ifb.pred_valid_out, 1);
      rst_in = 1'b1;
      #1;
      check_eq("run_rst_vld", ifb.pred_valid_out, 0);
      check_eq("run_rst_taken", ifb.branch_taken_out, 0);
      check_eq("run_rst_pidx", ifb.pred_index_out, 0);
      check_eq("run_rst_ready", ifb.ready_out, 0);
      tick();
      rst_in = 1'b0;
      wait_ready("ready_lat4", 0);
      cnt = 0;
      for (int i = 0; i < 64; i++) begin
         lookup(32'(i) << 2);
         cnt += int'(ifb.branch_taken_out) + int'(ifa.branch_taken_out);
      end
      check_eq("sweep_all_nt", cnt, 0);

      // 3-bit counters at index 2: start 3, saturate at 7
      lookup(32'h8);  check_eq("c3_init", ifc.branch_taken_out, 0);
      for (int i = 0; i < 7; i++) update(6'd2, 1'b1);
      lookup(32'h8);  check_eq("c3_7T", ifc.branch_taken_out, 1);
      update(6'd2, 1'b0);
      lookup(32'h8);  check_eq("c3_N1", ifc.branch_taken_out, 1);
      update(6'd2, 1'b0); update(6'd2, 1'b0);
      lookup(32'h8);  check_eq("c3_N3", ifc.branch_taken_out, 1);
      update(6'd2, 1'b0);
      lookup(32'h8);  check_eq("c3_N4", ifc.branch_taken_out, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
